// File: rtl/pattern_gen_multi.sv
// Multi-pattern HDMI test source. Produces one registered RGB565 pixel
// per requested coordinate. Five patterns are available, selected through
// a pending register that is applied on frame boundaries. Mode 4 scrolls
// its bars by SCROLL_STEP lines per frame.
module pattern_gen_multi #(
  parameter int unsigned BAR_SHIFT   = 6,
  parameter int unsigned CHK_SHIFT   = 5,
  parameter int unsigned SCROLL_STEP = 1,
  parameter int unsigned POS_W       = 12,
  parameter int unsigned FCNT_W      = 16
) (
  input  logic              pixel_clk,
  input  logic              sys_rst_n,
  input  logic [POS_W-1:0]  pixel_xpos,
  input  logic [POS_W-1:0]  pixel_ypos,
  input  logic              frame_start,
  input  logic [2:0]        mode_sel,
  input  logic              mode_we,
  output logic [15:0]       rd_data,
  output logic [2:0]        cur_mode,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam logic [2:0] MODE_SCROLL = 3'd4;

  // Four-entry bar palette shared by the bar patterns.
  function automatic logic [15:0] palette(input logic [1:0] idx);
    case (idx)
      2'd0:    palette = 16'h07E0;
      2'd1:    palette = 16'hF800;
      2'd2:    palette = 16'h001F;
      default: palette = 16'h07FF;
    endcase
  endfunction

  logic [2:0]        pend_q, pend_d;
  logic [2:0]        cur_q, cur_d;
  logic [POS_W-1:0]  off_q, off_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [15:0]       rd_q, rd_d;
  logic [POS_W-1:0]  y_scroll;
  logic [4:0]        grad_r;
  logic [5:0]        grad_g;

  // Coordinate bits that no pattern looks at.
  logic unused_coord_bits;
  assign unused_coord_bits = ^{pixel_xpos, pixel_ypos};

  // Next-state for the mode registers, scroll offset, frame counter and pixel.
  // The pixel in a frame_start cycle must already see the new mode and
  // offset, so the pattern is decoded from the _d values, not the _q values.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a variable unassigned, which would infer a latch.
    pend_d   = pend_q;
    cur_d    = cur_q;
    off_d    = off_q;
    fcnt_d   = fcnt_q;
    rd_d     = 16'h0000;
    y_scroll = '0;
    grad_r   = '0;
    grad_g   = '0;

    if (mode_we && (mode_sel <= MODE_SCROLL)) begin
      pend_d = mode_sel;
    end

    if (frame_start) begin
      cur_d  = pend_d;
      fcnt_d = fcnt_q + 1'b1;
      if (pend_d == MODE_SCROLL) begin
        // Entering scroll mode restarts the offset; staying in it advances.
        off_d = (cur_q == MODE_SCROLL) ? off_q + POS_W'(SCROLL_STEP) : '0;
      end
    end

    y_scroll = pixel_ypos + off_d;
    grad_r   = pixel_xpos[8:4];
    grad_g   = pixel_ypos[8:3];

    case (cur_d)
      3'd0: rd_d = palette(pixel_ypos[BAR_SHIFT+1:BAR_SHIFT]);
      3'd1: rd_d = palette(pixel_xpos[BAR_SHIFT+1:BAR_SHIFT]);
      3'd2: rd_d = (pixel_xpos[CHK_SHIFT] ^ pixel_ypos[CHK_SHIFT]) ? 16'hFFFF : 16'h0000;
      3'd3: rd_d = {grad_r, grad_g, ~grad_r};
      3'd4: rd_d = palette(y_scroll[BAR_SHIFT+1:BAR_SHIFT]);
      default: rd_d = 16'h0000;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    if (!sys_rst_n) begin
      pend_q <= '0;
      cur_q  <= '0;
      off_q  <= '0;
      fcnt_q <= '0;
      rd_q   <= 16'h0000;
    end else begin
      pend_q <= pend_d;
      cur_q  <= cur_d;
      off_q  <= off_d;
      fcnt_q <= fcnt_d;
      rd_q   <= rd_d;
    end
  end

  assign rd_data   = rd_q;
  assign cur_mode  = cur_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_pattern_gen_multi.sv
// Self-checking bench for pattern_gen_multi: a behavioural model compared
// every cycle, plus hand-computed literal expectations.
module tb_pattern_gen_multi;

  logic        pixel_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [11:0] pixel_xpos = '0;
  logic [11:0] pixel_ypos = '0;
  logic        frame_start = 1'b0;
  logic [2:0]  mode_sel = '0;
  logic        mode_we = 1'b0;
  logic [15:0] rd_data;
  logic [2:0]  cur_mode;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  pattern_gen_multi dut (
    .pixel_clk   (pixel_clk),
    .sys_rst_n   (sys_rst_n),
    .pixel_xpos  (pixel_xpos),
    .pixel_ypos  (pixel_ypos),
    .frame_start (frame_start),
    .mode_sel    (mode_sel),
    .mode_we     (mode_we),
    .rd_data     (rd_data),
    .cur_mode    (cur_mode),
    .frame_cnt   (frame_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_pend, m_cur, m_off;
  logic [15:0] m_fcnt, m_rd;

  function automatic int pal(input int idx);
    case (idx)
      0:       return 16'h07E0;
      1:       return 16'hF800;
      2:       return 16'h001F;
      default: return 16'h07FF;
    endcase
  endfunction

  function automatic int f_pat(input int mode, input int x, input int y, input int off);
    int r, g;
    case (mode)
      0: return pal((y / 64) % 4);
      1: return pal((x / 64) % 4);
      2: return (((x / 32) + (y / 32)) % 2 == 1) ? 16'hFFFF : 16'h0000;
      3: begin
        r = (x / 16) % 32;
        g = (y / 8) % 64;
        return r * 2048 + g * 32 + (31 - r);
      end
      4: return pal((((y + off) % 4096) / 64) % 4);
      default: return 0;
    endcase
  endfunction

  function automatic int f_pend();
    return (mode_we && mode_sel <= 3'd4) ? int'(mode_sel) : m_pend;
  endfunction

  function automatic int f_eff();
    return frame_start ? f_pend() : m_cur;
  endfunction

  function automatic int f_off();
    if (frame_start && f_pend() == 4) return (m_cur == 4) ? (m_off + 1) % 4096 : 0;
    return m_off;
  endfunction

  // Model state advances on the same edge as the design.
  always @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_pend <= 0;
      m_cur  <= 0;
      m_off  <= 0;
      m_fcnt <= '0;
      m_rd   <= '0;
    end else begin
      m_pend <= f_pend();
      m_cur  <= f_eff();
      m_off  <= f_off();
      m_fcnt <= frame_start ? m_fcnt + 16'd1 : m_fcnt;
      m_rd   <= 16'(f_pat(f_eff(), int'(pixel_xpos), int'(pixel_ypos), f_off()));
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge pixel_clk) begin
    if (cmp_en) begin
      check("cmp_rd_data", 32'(rd_data), 32'(m_rd));
      check("cmp_cur_mode", 32'(cur_mode), 32'(m_cur));
      check("cmp_frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    end
  end

  // Apply one pixel request and return 1 time unit after the sampling edge.
  task automatic step(input int x, input int y, input bit fs, input bit we, input int sel);
    pixel_xpos  = 12'(x);
    pixel_ypos  = 12'(y);
    frame_start = fs;
    mode_we     = we;
    mode_sel    = 3'(sel);
    @(posedge pixel_clk);
    #1;
    frame_start = 1'b0;
    mode_we     = 1'b0;
  endtask

  int ys[5] = '{0, 64, 128, 192, 256};
  int exp0[5] = '{16'h07E0, 16'hF800, 16'h001F, 16'h07FF, 16'h07E0};

  initial begin
    #22;
    check("reset_rd_data", 32'(rd_data), 32'h0000);
    check("reset_cur_mode", 32'(cur_mode), 32'd0);
    check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    sys_rst_n = 1'b1;
    @(posedge pixel_clk);
    #1;
    cmp_en = 1'b1;

    // Mode 0 horizontal bars.
    for (int i = 0; i < 5; i++) begin
      step(0, ys[i], 1'b0, 1'b0, 0);
      check("mode0_bar", 32'(rd_data), 32'(exp0[i]));
    end

    // Mid-frame write is deferred to the next frame_start.
    step(0, 0, 1'b0, 1'b1, 1);
    check("deferred_mode", 32'(cur_mode), 32'd0);
    step(70, 0, 1'b0, 1'b0, 0);
    check("deferred_still_mode0", 32'(rd_data), 32'h07E0);
    step(70, 0, 1'b1, 1'b0, 0);
    check("mode1_applied", 32'(cur_mode), 32'd1);
    check("mode1_x70", 32'(rd_data), 32'hF800);

    // Checkerboard.
    step(0, 0, 1'b0, 1'b1, 2);
    step(0, 0, 1'b1, 1'b0, 0);
    check("chk_0_0", 32'(rd_data), 32'h0000);
    step(32, 0, 1'b0, 1'b0, 0);
    check("chk_32_0", 32'(rd_data), 32'hFFFF);
    step(32, 32, 1'b0, 1'b0, 0);
    check("chk_32_32", 32'(rd_data), 32'h0000);

    // Gradient via simultaneous write and frame_start.
    step(12'h1F0, 12'h1F8, 1'b1, 1'b1, 3);
    check("simul_mode3", 32'(cur_mode), 32'd3);
    check("grad_max", 32'(rd_data), 32'hFFE0);
    step(0, 0, 1'b0, 1'b0, 0);
    check("grad_zero", 32'(rd_data), 32'h001F);

    // Invalid mode write is ignored.
    step(0, 0, 1'b0, 1'b1, 6);
    step(0, 0, 1'b1, 1'b0, 0);
    check("invalid_ignored", 32'(cur_mode), 32'd3);

    // Scrolling bars.
    step(0, 0, 1'b0, 1'b1, 4);
    step(0, 63, 1'b1, 1'b0, 0);
    check("scroll_switch_in", 32'(rd_data), 32'h07E0);
    step(0, 63, 1'b0, 1'b0, 0);
    check("scroll_hold", 32'(rd_data), 32'h07E0);
    step(0, 63, 1'b1, 1'b0, 0);
    check("scroll_off1", 32'(rd_data), 32'hF800);
    for (int i = 0; i < 4094; i++) begin
      step((i * 7) % 4096, (i * 13) % 4096, 1'b1, 1'b0, 0);
    end
    step(0, 0, 1'b0, 1'b0, 0);
    check("scroll_off4095", 32'(rd_data), 32'h07FF);
    step(0, 0, 1'b1, 1'b0, 0);
    check("scroll_wrap", 32'(rd_data), 32'h07E0);

    // Mid-frame reset.
    step(100, 200, 1'b0, 1'b0, 0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("midrst_rd_data", 32'(rd_data), 32'h0000);
    check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("midrst_cur_mode", 32'(cur_mode), 32'd0);
    @(posedge pixel_clk);
    #3;
    sys_rst_n = 1'b1;
    step(0, 64, 1'b0, 1'b0, 0);
    check("post_rst_mode0", 32'(rd_data), 32'hF800);
    step(0, 0, 1'b1, 1'b0, 0);
    check("post_rst_fcnt", 32'(frame_cnt), 32'd1);
    @(negedge pixel_clk);
    cmp_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
